blit_engine: RTL and testbench

Parametrised pixel blitter for the bomberman display path. It copies a full background screen or one sprite-sheet tile into the frame buffer, or streams the frame buffer to the VGA adapter (refresh).
- Tile blits are placed at an arbitrary (dst_x, dst_y), clipped at screen edges, and use a colour-key for transparency.
- Memories are external; the engine drives synchronous one-cycle-latency read/write ports and sits between the game FSM and the VGA adapter.

---
 rtl/blit_pkg.sv | 47 ++++
 rtl/blit_scan_counter.sv | 58 +++++
 rtl/blit_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_blit_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the blitter: command encodings, FSM states, default
// geometry and the sprite-sheet address helper.
package blit_pkg;

  localparam int unsigned ADDR_W = 17;

  // Command encodings on the mode input; 3 is reserved and treated as a no-op
  localparam logic [1:0] MODE_SCREEN  = 2'd0;
  localparam logic [1:0] MODE_TILE    = 2'd1;
  localparam logic [1:0] MODE_REFRESH = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWrite,
    StDone
  } blit_state_e;

  // Default geometry and colour
  localparam int unsigned DEF_WIDTH      = 320;
  localparam int unsigned DEF_HEIGHT     = 240;
  localparam int unsigned DEF_COLOUR_W   = 6;
  localparam int unsigned DEF_TILE_W     = 16;
  localparam int unsigned DEF_TILE_H     = 16;
  localparam int unsigned DEF_SHEET_COLS = 4;
  localparam int unsigned DEF_NUM_SRC    = 4;
  localparam int unsigned DEF_KEY_COLOUR = 32'b001100;

  // Linear sheet address of pixel (col, row) inside tile 'tile'; the sheet is
  // sheet_cols tiles wide and stored row-major.
  function automatic logic [ADDR_W-1:0] sheet_addr(input logic [7:0]  tile,
                                                   input logic [8:0]  col,
                                                   input logic [7:0]  row,
                                                   input int unsigned tile_w,
                                                   input int unsigned tile_h,
                                                   input int unsigned sheet_cols);
    int unsigned trow;
    int unsigned tcol;
    int unsigned addr;
    trow = 32'(tile) / sheet_cols;
    tcol = 32'(tile) % sheet_cols;
    addr = (trow * tile_h + 32'(row)) * (sheet_cols * tile_w) + tcol * tile_w + 32'(col);
    return ADDR_W'(addr);
  endfunction

endpackage

// File: rtl/blit_scan_counter.sv
// Raster xy counter: x runs 0..max_x, wraps while y increments, last_o flags
// the final (max_x, max_y) position. Clear has priority over enable.
module blit_scan_counter #(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [XW-1:0] max_x_i,
  input  logic [YW-1:0] max_y_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_x;
  logic          last_y;

  assign last_x = (x_q == max_x_i);
  assign last_y = (y_q == max_y_i);

  // Next position: clear, or step x with wrap into y
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = last_x && last_y;

endmodule

// File: rtl/blit_engine.sv
// Pixel blitter: full-screen copy into the frame buffer, keyed/clipped tile
// blit from the sprite sheet, or frame-buffer refresh to the VGA adapter.
// Two cycles per pixel (address, then write with one-cycle read data).
// Optional macro BLIT_FLIP_EN adds flip_h for horizontally mirrored tiles.
module blit_engine
  import blit_pkg::*;
#(
  parameter int unsigned         WIDTH      = DEF_WIDTH,
  parameter int unsigned         HEIGHT     = DEF_HEIGHT,
  parameter int unsigned         COLOUR_W   = DEF_COLOUR_W,
  parameter int unsigned         TILE_W     = DEF_TILE_W,
  parameter int unsigned         TILE_H     = DEF_TILE_H,
  parameter int unsigned         SHEET_COLS = DEF_SHEET_COLS,
  parameter int unsigned         NUM_SRC    = DEF_NUM_SRC,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(DEF_KEY_COLOUR)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [$clog2(NUM_SRC)-1:0] src_sel,
  input  logic [7:0]                 tile_sel,
  input  logic [8:0]                 dst_x,
  input  logic [7:0]                 dst_y,
`ifdef BLIT_FLIP_EN
  input  logic                       flip_h,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_SRC)-1:0] src_sel_o,
  output logic [16:0]                src_addr,
  input  logic [COLOUR_W-1:0]        src_data,
  output logic [16:0]                buf_addr,
  output logic [COLOUR_W-1:0]        buf_wdata,
  output logic                       buf_we,
  input  logic [COLOUR_W-1:0]        buf_rdata,
  output logic [8:0]                 vga_x,
  output logic [7:0]                 vga_y,
  output logic [COLOUR_W-1:0]        vga_colour,
  output logic                       vga_we
);

  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned SW = $clog2(NUM_SRC);

  if (WIDTH * HEIGHT > (1 << ADDR_W)) begin : g_size_check
    $error("blit_engine: WIDTH*HEIGHT does not fit the 17-bit address space");
  end

  blit_state_e state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [SW-1:0] src_sel_q, src_sel_d;
  logic [7:0]  tile_q, tile_d;
  logic [8:0]  dst_x_q, dst_x_d;
  logic [7:0]  dst_y_q, dst_y_d;
  logic        flip;

  logic          load;
  logic          cnt_en;
  logic [XW-1:0] sx, max_x;
  logic [YW-1:0] sy, max_y;
  logic          last;

  logic [9:0]        px;
  logic [8:0]        py;
  logic [XW-1:0]     sheet_col;
  logic [ADDR_W-1:0] scr_addr;
  logic [ADDR_W-1:0] tile_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              in_bounds;
  logic              active;
  logic              wr;

`ifdef BLIT_FLIP_EN
  logic flip_q, flip_d;

  // Mirror select is captured with the rest of the command
  always_comb begin
    flip_d = flip_q;
    if (load) flip_d = flip_h;
  end

  // Mirror select register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flip_q <= 1'b0;
    else          flip_q <= flip_d;
  end

  assign flip = flip_q;
`else
  assign flip = 1'b0;
`endif

  // Command FSM: accept in idle, alternate address/write per pixel, pulse done
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (mode != MODE_RSVD)) begin
          state_d = StAddr;
          load    = 1'b1;
        end
      end
      StAddr:  state_d = StWrite;
      StWrite: begin
        cnt_en  = 1'b1;
        state_d = last ? StDone : StAddr;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command latches; the sheet is its own ROM so tile blits report source 0
  always_comb begin
    mode_d    = mode_q;
    src_sel_d = src_sel_q;
    tile_d    = tile_q;
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    if (load) begin
      mode_d    = mode;
      src_sel_d = (mode == MODE_TILE) ? '0 : src_sel;
      tile_d    = tile_sel;
      dst_x_d   = dst_x;
      dst_y_d   = dst_y;
    end
  end

  // State and command registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      mode_q    <= MODE_SCREEN;
      src_sel_q <= '0;
      tile_q    <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_sel_q <= src_sel_d;
      tile_q    <= tile_d;
      dst_x_q   <= dst_x_d;
      dst_y_q   <= dst_y_d;
    end
  end

  assign max_x = (mode_q == MODE_TILE) ? XW'(TILE_W - 1) : XW'(WIDTH - 1);
  assign max_y = (mode_q == MODE_TILE) ? YW'(TILE_H - 1) : YW'(HEIGHT - 1);

  blit_scan_counter #(
    .XW (XW),
    .YW (YW)
  ) u_scan (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (load),
    .en_i    (cnt_en),
    .max_x_i (max_x),
    .max_y_i (max_y),
    .x_o     (sx),
    .y_o     (sy),
    .last_o  (last)
  );

  // Address arithmetic; destination is widened so edge overflow clips, not wraps
  always_comb begin
    px        = {1'b0, dst_x_q} + 10'(sx);
    py        = {1'b0, dst_y_q} + 9'(sy);
    sheet_col = flip ? (XW'(TILE_W - 1) - sx) : sx;
    scr_addr  = ADDR_W'(32'(sy) * WIDTH + 32'(sx));
    tile_addr = sheet_addr(tile_q, sheet_col, sy, TILE_W, TILE_H, SHEET_COLS);
    dst_addr  = ADDR_W'(32'(py) * WIDTH + 32'(px));
    in_bounds = (32'(px) < WIDTH) && (32'(py) < HEIGHT);
  end

  assign active = (state_q == StAddr) || (state_q == StWrite);
  assign wr     = (state_q == StWrite);

  // Memory and VGA ports; addresses are held through the pixel, strobes only in write
  always_comb begin
    src_addr   = '0;
    buf_addr   = '0;
    buf_wdata  = '0;
    buf_we     = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_we     = 1'b0;
    if (active) begin
      case (mode_q)
        MODE_SCREEN: begin
          src_addr = scr_addr;
          buf_addr = scr_addr;
          if (wr) begin
            buf_we    = 1'b1;
            buf_wdata = src_data;
          end
        end
        MODE_TILE: begin
          src_addr = tile_addr;
          buf_addr = dst_addr;
          if (wr && in_bounds && (src_data != KEY_COLOUR)) begin
            buf_we    = 1'b1;
            buf_wdata = src_data;
          end
        end
        MODE_REFRESH: begin
          buf_addr = scr_addr;
          if (wr) begin
            vga_we     = 1'b1;
            vga_x      = sx;
            vga_y      = sy;
            vga_colour = buf_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign src_sel_o = src_sel_q;

endmodule

// File: tb/tb_blit_engine.sv
// Self-checking bench for blit_engine on a reduced 32x24 screen: models the
// screen/sheet ROMs and frame buffer, predicts every write into scoreboards.
module tb_blit_engine;

  localparam int unsigned W   = 32;
  localparam int unsigned H   = 24;
  localparam int unsigned CW  = 6;
  localparam int unsigned NPX = W * H;
  localparam int unsigned TPX = 16 * 16;
  localparam logic [CW-1:0] KEY = 6'b001100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    src_sel = 2'd0;
  logic [7:0]    tile_sel = 8'd0;
  logic [8:0]    dst_x = 9'd0;
  logic [7:0]    dst_y = 8'd0;
`ifdef BLIT_FLIP_EN
  logic          flip_h = 1'b0;
`endif
  logic          busy, done, buf_we, vga_we;
  logic [1:0]    src_sel_o;
  logic [16:0]   src_addr, buf_addr;
  logic [CW-1:0] src_data, buf_wdata, buf_rdata, vga_colour;
  logic [8:0]    vga_x;
  logic [7:0]    vga_y;

  blit_engine #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .src_sel    (src_sel),
    .tile_sel   (tile_sel),
    .dst_x      (dst_x),
    .dst_y      (dst_y),
`ifdef BLIT_FLIP_EN
    .flip_h     (flip_h),
`endif
    .busy       (busy),
    .done       (done),
    .src_sel_o  (src_sel_o),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .buf_we     (buf_we),
    .buf_rdata  (buf_rdata),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_we     (vga_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int vga_cnt  = 0;
  bit tile_active = 1'b0;

  logic [CW-1:0] fb     [NPX];
  logic [CW-1:0] ref_fb [NPX];
  logic [31:0]   exp_buf_q[$];
  logic [31:0]   exp_vga_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] scr_pix(input int unsigned sel, input int unsigned a);
    return CW'((a + sel * 7) & 63);
  endfunction

  // Tile 5 has the colour key at its (0,0) pixel, sheet address 16*64+16
  function automatic logic [CW-1:0] sheet_pix(input int unsigned a);
    return (a == 1040) ? KEY : CW'(a & 63);
  endfunction

  // External memories: one-cycle read latency
  always @(posedge clk) begin
    src_data <= tile_active ? sheet_pix(32'(src_addr)) : scr_pix(32'(src_sel_o), 32'(src_addr));
    buf_rdata <= (32'(buf_addr) < NPX) ? fb[buf_addr] : '0;
    if (buf_we && (32'(buf_addr) < NPX)) fb[buf_addr] <= buf_wdata;
  end

  // Scoreboard consumers
  always @(negedge clk) begin
    logic [31:0] e;
    if (buf_we) begin
      wr_cnt++;
      if (exp_buf_q.size() == 0) chk("buf_unexpected", {9'b0, buf_addr, buf_wdata}, 32'hffffffff);
      else begin
        e = exp_buf_q.pop_front();
        chk("buf_wr", {9'b0, buf_addr, buf_wdata}, e);
      end
    end
    if (vga_we) begin
      vga_cnt++;
      if (exp_vga_q.size() == 0) chk("vga_unexpected", {9'b0, vga_x, vga_y, vga_colour}, 32'hffffffff);
      else begin
        e = exp_vga_q.pop_front();
        chk("vga_wr", {9'b0, vga_x, vga_y, vga_colour}, e);
      end
    end
  end

  task automatic push_screen(input int unsigned sel);
    for (int unsigned a = 0; a < NPX; a++) begin
      exp_buf_q.push_back({9'b0, 17'(a), scr_pix(sel, a)});
      ref_fb[a] = scr_pix(sel, a);
    end
  endtask

  task automatic push_refresh();
    for (int unsigned y = 0; y < H; y++)
      for (int unsigned x = 0; x < W; x++)
        exp_vga_q.push_back({9'b0, 9'(x), 8'(y), ref_fb[y * W + x]});
  endtask

  task automatic push_tile(input int unsigned tile, input int unsigned dx, input int unsigned dy,
                           input bit fl, output int n);
    int unsigned col, a, px, py;
    logic [CW-1:0] d;
    n = 0;
    for (int unsigned ty = 0; ty < 16; ty++)
      for (int unsigned tx = 0; tx < 16; tx++) begin
        col = fl ? 15 - tx : tx;
        a   = ((tile / 4) * 16 + ty) * 64 + (tile % 4) * 16 + col;
        d   = sheet_pix(a);
        px  = dx + tx;
        py  = dy + ty;
        if (d != KEY && px < W && py < H) begin
          exp_buf_q.push_back({9'b0, 17'(py * W + px), d});
          ref_fb[py * W + px] = d;
          n++;
        end
      end
  endtask

  // Issue one command and check its timing; n_pix is the pixel count
  task automatic run_cmd(input string tag, input logic [1:0] m, input logic [1:0] sel,
                         input int unsigned tile, input int unsigned dx, input int unsigned dy,
                         input bit fl, input int n_pix);
    int cyc, busy_cnt;
    bit seen;
    @(negedge clk);
    mode = m; src_sel = sel; tile_sel = 8'(tile); dst_x = 9'(dx); dst_y = 8'(dy);
`ifdef BLIT_FLIP_EN
    flip_h = fl;
`endif
    tile_active = (m == 2'd1);
    start = 1'b1;
    wr_cnt = 0; vga_cnt = 0; cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 2 * n_pix + 20) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_cycle"}, cyc, 2 * n_pix + 1);
    chk({tag, "_busy_cycles"}, busy_cnt, 2 * n_pix + 1);
    @(negedge clk);
    chk({tag, "_idle_after"}, {30'b0, busy, done}, 32'd0);
    chk({tag, "_buf_sb_empty"}, exp_buf_q.size(), 0);
    chk({tag, "_vga_sb_empty"}, exp_vga_q.size(), 0);
  endtask

  initial begin
    int n, cnt;
    // Reset state
    #1;
    chk("rst_outputs", 32'(|{busy, done, buf_we, vga_we, src_sel_o, src_addr, buf_addr,
                              buf_wdata, vga_x, vga_y, vga_colour}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reserved mode: stays idle, no done
    @(negedge clk);
    mode = 2'd3; start = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) cnt++;
    end
    chk("rsvd_idle", cnt, 0);

    // Screen copy from source 2
    push_screen(2);
    run_cmd("copy", 2'd0, 2'd2, 0, 0, 0, 0, NPX);
    chk("copy_writes", wr_cnt, NPX);
    chk("copy_src_sel", src_sel_o, 2);

    // Refresh after copy
    push_refresh();
    run_cmd("refresh1", 2'd2, 2'd0, 0, 0, 0, 0, NPX);
    chk("refresh1_vga_cnt", vga_cnt, NPX);

    // Keyed tile blit, fully on screen
    push_tile(5, 10, 5, 0, n);
    run_cmd("tile5", 2'd1, 2'd3, 5, 10, 5, 0, TPX);
    chk("tile5_writes", wr_cnt, 255);
    chk("tile5_src_sel", src_sel_o, 0);
    chk("tile5_key_kept", fb[5 * W + 10], scr_pix(2, 5 * W + 10));
    chk("tile5_pix1", fb[5 * W + 11], 17);

    // Tile clipped at the bottom-right corner
    push_tile(0, W - 8, H - 4, 0, n);
    run_cmd("clip", 2'd1, 2'd0, 0, W - 8, H - 4, 0, TPX);
    chk("clip_writes", wr_cnt, 32);

    push_refresh();
    run_cmd("refresh2", 2'd2, 2'd0, 0, 0, 0, 0, NPX);
    chk("refresh2_vga_cnt", vga_cnt, NPX);

`ifdef BLIT_FLIP_EN
    push_tile(0, 0, 0, 1, n);
    run_cmd("flip", 2'd1, 2'd0, 0, 0, 0, 1, TPX);
    chk("flip_writes", wr_cnt, 240);
    chk("flip_pix0", fb[0], 15);
    chk("flip_pix15", fb[15], 0);
`endif

    // Second start while busy is ignored, then reset mid-operation
    push_tile(5, 10, 5, 0, n);
    @(negedge clk);
    mode = 2'd1; tile_sel = 8'd5; dst_x = 9'd10; dst_y = 8'd5; tile_active = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    mode = 2'd0; src_sel = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_src_sel", src_sel_o, 0);
    chk("busy_start_busy", 32'(busy), 1);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'(|{busy, done, buf_we, vga_we, src_sel_o, src_addr, buf_addr,
                                buf_wdata, vga_x, vga_y, vga_colour}), 32'd0);
    exp_buf_q.delete();
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("midrst_no_done", cnt, 0);

    // Fresh command after release runs normally
    push_screen(1);
    run_cmd("copy2", 2'd0, 2'd1, 0, 0, 0, 0, NPX);
    chk("copy2_writes", wr_cnt, NPX);
    push_refresh();
    run_cmd("refresh3", 2'd2, 2'd0, 0, 0, 0, 0, NPX);
    chk("refresh3_vga_cnt", vga_cnt, NPX);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
